// File: rtl/apb_modport.sv
// apb_modport: self-contained APB subsystem.
//
// One APB master bridge turns simple transfer requests into full SETUP/ACCESS
// cycles on an internal APB bus that serves two zero-wait-state memory slaves.
// Address bit AW-1 selects the slave (0: slave 1, 1: slave 2). Bits AW-2:0 are
// the word index inside the selected slave.
//
// Ports:
//   pclk              in   system clock, rising edge
//   presetn           in   asynchronous active-low reset
//   transfer          in   request a transfer (sampled at rising pclk)
//   read_write        in   1 = write, 0 = read
//   apb_write_paddr   in   address used for writes
//   apb_write_data    in   data used for writes
//   apb_read_paddr    in   address used for reads
//   apb_read_data_out out  registered data of the last completed read

module apb_modport #(
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out
);

    localparam int unsigned IW = AW - 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Captured request; only these drive the bus once a transfer is in flight.
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          capture;

    // Internal APB bus.
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic [IW-1:0] word_idx;

    // Slave-side signals.
    logic          pready1;
    logic          pready2;
    logic [DW-1:0] prdata1;
    logic [DW-1:0] prdata2;
    logic          pslverr1;
    logic          pslverr2;
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];

    // ------------------------------------------------------------------
    // Master FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        unique case (state)
            StIdle: begin
                if (transfer) begin
                    state_next = StSetup;
                    capture    = 1'b1;
                end
            end
            StSetup: begin
                state_next = StAccess;
            end
            StAccess: begin
                if (pready) begin
                    if (transfer) begin
                        // Back-to-back: next request goes straight to SETUP.
                        state_next = StSetup;
                        capture    = 1'b1;
                    end else begin
                        state_next = StIdle;
                    end
                end
            end
            default: begin
                state_next = StIdle;
            end
        endcase
    end

    // Request capture: the address source follows the direction of the request.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (capture) begin
            pwrite <= read_write;
            paddr  <= read_write ? apb_write_paddr : apb_read_paddr;
            pwdata <= apb_write_data;
        end
    end

    // Bus outputs are decoded from state so they are 0 in IDLE and in reset.
    always_comb begin
        psel1   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
        if (state == StSetup || state == StAccess) begin
            psel1 = ~paddr[AW-1];
            psel2 = paddr[AW-1];
        end
        if (state == StAccess) begin
            penable = 1'b1;
        end
    end

    assign word_idx = paddr[IW-1:0];

    // Return path from whichever slave is selected.
    always_comb begin
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        if (psel1) begin
            pready  = pready1;
            prdata  = prdata1;
            pslverr = pslverr1;
        end else if (psel2) begin
            pready  = pready2;
            prdata  = prdata2;
            pslverr = pslverr2;
        end
    end

    // Read data is registered only on a successful read completion; writes
    // leave it untouched.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            apb_read_data_out <= '0;
        end else if (state == StAccess && pready && !pwrite && !pslverr) begin
            apb_read_data_out <= prdata;
        end
    end

    // ------------------------------------------------------------------
    // Slave 1: zero wait state memory
    // ------------------------------------------------------------------
    assign pready1  = psel1 & penable;
    assign pslverr1 = 1'b0;
    assign prdata1  = pready1 ? mem1[word_idx] : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem1[i] <= '0;
            end
        end else if (psel1 && penable && pwrite) begin
            mem1[word_idx] <= pwdata;
        end
    end

    // ------------------------------------------------------------------
    // Slave 2: zero wait state memory
    // ------------------------------------------------------------------
    assign pready2  = psel2 & penable;
    assign pslverr2 = 1'b0;
    assign prdata2  = pready2 ? mem2[word_idx] : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem2[i] <= '0;
            end
        end else if (psel2 && penable && pwrite) begin
            mem2[word_idx] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_modport.sv
// Testbench for apb_modport: table of directed transfers plus hand-written
// sequences for asynchronous reset mid-ACCESS and back-to-back transfers.

module tb_apb_modport;

    logic       pclk;
    logic       presetn;
    logic       transfer;
    logic       read_write;
    logic [8:0] apb_write_paddr;
    logic [7:0] apb_write_data;
    logic [8:0] apb_read_paddr;
    logic [7:0] apb_read_data_out;

    int n_cmp;
    int n_err;
    logic [7:0] model_rd;

    apb_modport #(
        .AW    (9),
        .DW    (8),
        .DEPTH (256)
    ) dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic       rw;
        logic [8:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [15];
    vec_t bb   [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request so it is captured at the next rising edge.
    task automatic apply(input logic rw, input logic [8:0] addr, input logic [7:0] data);
        read_write = rw;
        if (rw) begin
            apb_write_paddr = addr;
            apb_read_paddr  = addr ^ 9'h1AA;
        end else begin
            apb_read_paddr  = addr;
            apb_write_paddr = addr ^ 9'h0C3;
        end
        apb_write_data = data;
    endtask

    // Single isolated transfer. Inputs are scrambled after capture to show
    // only the captured request matters; the old read value must still be
    // present just before the completing edge.
    task automatic xfer(input logic rw, input logic [8:0] addr, input logic [7:0] data,
                        input logic [7:0] exp, input string name);
        @(negedge pclk);
        apply(rw, addr, data);
        transfer = 1'b1;
        @(posedge pclk);                 // edge N: capture
        @(negedge pclk);
        transfer        = 1'b0;
        read_write      = ~rw;
        apb_read_paddr  = apb_read_paddr ^ 9'h155;
        apb_write_paddr = apb_write_paddr ^ 9'h0F0;
        apb_write_data  = ~apb_write_data;
        @(posedge pclk);                 // edge N+1: SETUP -> ACCESS
        @(negedge pclk);
        check({name, "_before"}, apb_read_data_out, model_rd);
        @(posedge pclk);                 // edge N+2: completion
        #1;
        check(name, apb_read_data_out, exp);
        model_rd = exp;
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        model_rd        = 8'h00;
        presetn         = 1'b0;
        transfer        = 1'b0;
        read_write      = 1'b0;
        apb_write_paddr = '0;
        apb_write_data  = '0;
        apb_read_paddr  = '0;

        vecs[0]  = '{1'b1, 9'h005, 8'hA5, 8'h00, "w_005_a5"};
        vecs[1]  = '{1'b0, 9'h005, 8'h00, 8'hA5, "r_005_a5"};
        vecs[2]  = '{1'b1, 9'h005, 8'h11, 8'hA5, "w_005_11"};
        vecs[3]  = '{1'b1, 9'h105, 8'h22, 8'hA5, "w_105_22"};
        vecs[4]  = '{1'b0, 9'h005, 8'h00, 8'h11, "r_005_11"};
        vecs[5]  = '{1'b0, 9'h105, 8'h00, 8'h22, "r_105_22"};
        vecs[6]  = '{1'b1, 9'h0FF, 8'h7E, 8'h22, "w_0ff_7e"};
        vecs[7]  = '{1'b1, 9'h1FF, 8'h81, 8'h22, "w_1ff_81"};
        vecs[8]  = '{1'b0, 9'h0FF, 8'h00, 8'h7E, "r_0ff_7e"};
        vecs[9]  = '{1'b0, 9'h1FF, 8'h00, 8'h81, "r_1ff_81"};
        vecs[10] = '{1'b0, 9'h100, 8'h00, 8'h00, "r_100_unwritten"};
        vecs[11] = '{1'b1, 9'h030, 8'h5A, 8'h00, "w_030_5a"};
        vecs[12] = '{1'b0, 9'h030, 8'h00, 8'h5A, "r_030_5a"};
        vecs[13] = '{1'b1, 9'h031, 8'hFF, 8'h5A, "w_031_hold"};
        vecs[14] = '{1'b0, 9'h031, 8'h00, 8'hFF, "r_031_ff"};

        for (int k = 0; k < 4; k++) begin
            bb[k]     = '{1'b1, 9'(k), 8'(k + 1), 8'h00, "bb_w"};
            bb[k + 4] = '{1'b0, 9'(k), 8'h00, 8'(k + 1), "bb_r"};
        end

        // Reset state
        repeat (3) @(posedge pclk);
        #1;
        check("reset_out", apb_read_data_out, 8'h00);
        @(negedge pclk);
        presetn = 1'b1;

        // Preload a value, then abort a write with reset during ACCESS.
        xfer(1'b1, 9'h020, 8'h44, 8'h00, "pre_w_020");
        xfer(1'b0, 9'h020, 8'h00, 8'h44, "pre_r_020");
        @(negedge pclk);
        apply(1'b1, 9'h010, 8'h33);
        transfer = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        transfer = 1'b0;
        @(posedge pclk);                 // now in ACCESS
        #2;
        presetn = 1'b0;
        #1;
        check("reset_async_out", apb_read_data_out, 8'h00);
        @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        check("reset_hold_out", apb_read_data_out, 8'h00);
        model_rd = 8'h00;
        xfer(1'b0, 9'h010, 8'h00, 8'h00, "r_010_aborted");
        xfer(1'b0, 9'h020, 8'h00, 8'h00, "r_020_cleared");

        // Table of single transfers
        for (int i = 0; i < 15; i++) begin
            xfer(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].exp, vecs[i].name);
        end

        // Back-to-back with transfer held high: one transfer every 2 cycles.
        @(negedge pclk);
        apply(bb[0].rw, bb[0].addr, bb[0].data);
        transfer = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge pclk);             // completes k-1, captures k
            #1;
            if (k > 0 && !bb[k - 1].rw) begin
                check($sformatf("bb_r%0d", k - 5), apb_read_data_out, bb[k - 1].exp);
                model_rd = bb[k - 1].exp;
            end
            @(posedge pclk);             // SETUP -> ACCESS for k
            #1;
            check($sformatf("bb_mid%0d", k), apb_read_data_out, model_rd);
            @(negedge pclk);
            if (k < 7) begin
                apply(bb[k + 1].rw, bb[k + 1].addr, bb[k + 1].data);
            end else begin
                transfer = 1'b0;
            end
        end
        @(posedge pclk);
        #1;
        check("bb_r3", apply_dummy(), bb[7].exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic logic [7:0] apply_dummy();
        return apb_read_data_out;
    endfunction

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apb_modport.md
Name: apb_modport

Overview:
- Self-contained APB subsystem: one APB master bridge driving two APB memory slaves over an internal APB bus.
- Test-side users issue simple transfer requests (transfer, read_write, addresses, write data). The block runs full APB SETUP/ACCESS cycles and returns read data on apb_read_data_out.
- Address MSB selects slave 1 or slave 2.

Parameters:
- AW, 9: address width. Bit AW-1 selects the slave; bits AW-2:0 are the word index within the slave.
- DW, 8: data width of write data, read data and slave memory words.
- DEPTH, 256: words per slave memory (2**(AW-1)).

Ports:
- pclk  input  1  system clock; all state updates on rising edge.
- presetn  input  1  reset, asynchronous and active-low.
- transfer  input  1  request a transfer; sampled at rising pclk.
- read_write  input  1  1 = write, 0 = read.
- apb_write_paddr  input  AW  address used for writes.
- apb_write_data  input  DW  data used for writes.
- apb_read_paddr  input  AW  address used for reads.
- apb_read_data_out  output  DW  registered read data from the last completed read.

Behaviour:
- Reset (presetn low, asynchronous, any time): master returns to IDLE.
  - psel1, psel2, penable, pwrite, paddr and pwdata all clear to 0.
  - apb_read_data_out clears to 0.
  - Both slave memories clear to 0.
  - An in-flight transfer is abandoned; no memory write occurs.
- Master FSM states: IDLE, SETUP, ACCESS.
  - IDLE, transfer=0: stay in IDLE.
  - IDLE, transfer=1: go to SETUP. Capture read_write, the address (apb_write_paddr if write, else apb_read_paddr) and apb_write_data into internal pwrite/paddr/pwdata.
  - SETUP: drive psel1 = ~paddr[AW-1] and psel2 = paddr[AW-1], with penable=0. Always go to ACCESS next.
  - ACCESS: psel held, penable=1.
    - If the selected slave's pready=0: stay in ACCESS.
    - If pready=1 and transfer=1: go to SETUP, re-capturing the request as in IDLE (back-to-back).
    - If pready=1 and transfer=0: go to IDLE.
- Slaves:
  - Zero wait state: pready = psel & penable.
  - Write: mem[paddr[AW-2:0]] <= pwdata on the ACCESS edge with pwrite=1.
  - Read: prdata = mem[paddr[AW-2:0]] combinationally during ACCESS.
  - pslverr is tied to 0.
  - The unselected slave ignores the bus and keeps its contents.
- Read return: on the rising edge that completes a read ACCESS (pready=1, pwrite=0), apb_read_data_out <= prdata of the selected slave.
  - apb_read_data_out holds its value until the next completed read.
  - Writes never change apb_read_data_out.
- Latency:
  - transfer sampled high at edge N: SETUP during cycle N..N+1, ACCESS during N+1..N+2, completion at edge N+2.
  - Read data is visible after edge N+2.
  - Minimum 2 cycles per transfer; continuous back-to-back with transfer held high.
- Input changes while in SETUP/ACCESS do not affect the in-flight transfer. Only the captured values are used.
- Addresses 0x000-0x0FF map to slave 1; 0x100-0x1FF map to slave 2. No wrap between slaves.
- Reading a never-written location returns 0.

Test Plan:
- Reset: assert presetn=0 mid-ACCESS of a write to 0x010 -> apb_read_data_out=0. A later read of 0x010 returns 0 (write aborted).
- Single write then read, slave 1: write 0x005<=0xA5, then read 0x005 -> apb_read_data_out=0xA5 after the 3rd edge from the read request.
- Slave decode: write 0x005<=0x11 and 0x105<=0x22, then read 0x005 -> 0x11 and read 0x105 -> 0x22 (no aliasing).
- Back-to-back: hold transfer=1 over writes to 0x000..0x003 (data 1..4), then consecutive reads -> 1,2,3,4. Each transfer takes exactly 2 cycles with no IDLE between.
- Boundary addresses: write 0x0FF<=0x7E and 0x1FF<=0x81, read both -> 0x7E, 0x81. Read of unwritten 0x100 -> 0x00.
- Hold behaviour: after a read returns 0x5A, perform a write of 0xFF to another address -> apb_read_data_out stays 0x5A; input address changes during ACCESS do not change the result.
